// File: rtl/store_monitor.sv
// store_monitor: watches processor stores and reports pass, fail or timeout.
// Optional 4-entry store log, enabled by defining STORE_LOG_EN.
module store_monitor #(
  parameter logic [31:0] PASS_ADR  = 32'd84,
  parameter logic [31:0] PASS_DATA = 32'hFFFF_FFC0,
  parameter logic [31:0] ALLOW_ADR = 32'd80,
  parameter logic [15:0] TIMEOUT   = 16'd1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic [1:0]  fail_code,
  output logic [7:0]  store_count
`ifdef STORE_LOG_EN
  ,
  input  logic        log_rd,
  output logic        log_valid,
  output logic [31:0] log_adr,
  output logic [31:0] log_data,
  output logic        log_ovf
`endif
);

  typedef enum logic [1:0] {RUN, PASS, FAIL, TMO} state_t;

  localparam logic [1:0] CODE_NONE = 2'b00;
  localparam logic [1:0] CODE_ADR  = 2'b01;
  localparam logic [1:0] CODE_DATA = 2'b10;
  localparam logic [1:0] CODE_TMO  = 2'b11;

  state_t      state;
  state_t      state_next;
  logic [1:0]  code_next;
  logic [15:0] cycle_count;
  logic        store_in_run;
  logic        timeout_hit;

  assign store_in_run = (state == RUN) && memwrite;
  assign timeout_hit  = (cycle_count == (TIMEOUT - 16'd1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      fail_code <= CODE_NONE;
    end else begin
      state     <= state_next;
      fail_code <= code_next;
    end
  end

  // A store on the timeout cycle wins; address/data are only looked at under memwrite.
  always_comb begin
    state_next = state;
    code_next  = fail_code;
    if (state == RUN) begin
      if (memwrite) begin
        if (dataadr == PASS_ADR) begin
          if (writedata == PASS_DATA) begin
            state_next = PASS;
          end else begin
            state_next = FAIL;
            code_next  = CODE_DATA;
          end
        end else if (dataadr != ALLOW_ADR) begin
          state_next = FAIL;
          code_next  = CODE_ADR;
        end
      end else if (timeout_hit) begin
        state_next = TMO;
        code_next  = CODE_TMO;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count <= '0;
    end else if (state == RUN) begin
      cycle_count <= cycle_count + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      store_count <= '0;
    end else if (store_in_run && (store_count != 8'hFF)) begin
      store_count <= store_count + 8'd1;
    end
  end

  assign pass = (state == PASS);
  assign fail = (state == FAIL) || (state == TMO);
  assign done = pass | fail;

`ifdef STORE_LOG_EN
  logic [63:0] log_mem [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  log_count;
  logic        log_full;
  logic        log_push;
  logic        log_pop;

  assign log_full = (log_count == 3'd4);
  assign log_pop  = log_rd && (log_count != 3'd0);
  // A full log still accepts a store when the oldest entry leaves in the same cycle.
  assign log_push = store_in_run && (!log_full || log_pop);

  always_ff @(posedge clk) begin
    if (log_push) begin
      log_mem[wr_ptr] <= {dataadr, writedata};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      log_count <= '0;
      log_ovf   <= 1'b0;
    end else begin
      if (log_push) begin
        wr_ptr <= wr_ptr + 2'd1;
      end
      if (log_pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      if (store_in_run && log_full && !log_pop) begin
        log_ovf <= 1'b1;
      end
      case ({log_push, log_pop})
        2'b10:   log_count <= log_count + 3'd1;
        2'b01:   log_count <= log_count - 3'd1;
        default: log_count <= log_count;
      endcase
    end
  end

  assign log_valid           = (log_count != 3'd0);
  assign {log_adr, log_data} = log_mem[rd_ptr];
`else
  // Without the log the monitor carries no extra storage.
`endif

endmodule

// File: tb/tb_store_monitor.sv
// tb_store_monitor: table-driven and scoreboarded checks of store_monitor.
// Builds with or without STORE_LOG_EN; the log checks run only when it is defined.
module tb_store_monitor;

  localparam logic [31:0] PASSADR  = 32'd84;
  localparam logic [31:0] PASSDATA = 32'hFFFF_FFC0;
  localparam logic [31:0] ALLOWADR = 32'd80;

  logic        clk;
  logic        reset;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic        done;
  logic        pass;
  logic        fail;
  logic [1:0]  fail_code;
  logic [7:0]  store_count;
`ifdef STORE_LOG_EN
  logic        log_rd;
  logic        log_valid;
  logic [31:0] log_adr;
  logic [31:0] log_data;
  logic        log_ovf;
  logic [63:0] logModel[$];
  logic        logOvfModel;
`endif

  typedef struct packed {
    logic       done;
    logic       pass;
    logic       fail;
    logic [1:0] code;
    logic [7:0] count;
  } result_t;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] data;
    result_t     exp;
  } vector_t;

  result_t expq[$];
  vector_t vectors[7];
  int checks = 0;
  int errors = 0;

  store_monitor #(.TIMEOUT(16'd20)) dut (
    .clk(clk),
    .reset(reset),
    .memwrite(memwrite),
    .dataadr(dataadr),
    .writedata(writedata),
    .done(done),
    .pass(pass),
    .fail(fail),
    .fail_code(fail_code),
    .store_count(store_count)
`ifdef STORE_LOG_EN
    ,
    .log_rd(log_rd),
    .log_valid(log_valid),
    .log_adr(log_adr),
    .log_data(log_data),
    .log_ovf(log_ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic result_t mk(input logic d, input logic p, input logic f,
                                 input logic [1:0] c, input logic [7:0] n);
    mk = '{d, p, f, c, n};
  endfunction

  function automatic vector_t mkVec(input logic [31:0] a, input logic [31:0] w, input result_t e);
    mkVec = '{a, w, e};
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic checkOutput(input string name);
    result_t e;
    if (expq.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s actual=empty_scoreboard required=entry", name);
    end else begin
      e = expq.pop_front();
      cmp({name, ".done"}, {31'd0, done}, {31'd0, e.done});
      cmp({name, ".pass"}, {31'd0, pass}, {31'd0, e.pass});
      cmp({name, ".fail"}, {31'd0, fail}, {31'd0, e.fail});
      cmp({name, ".code"}, {30'd0, fail_code}, {30'd0, e.code});
      cmp({name, ".count"}, {24'd0, store_count}, {24'd0, e.count});
    end
  endtask

  // Drive one store cycle at the negedge; outputs are checked at the following negedge.
  task automatic applyStimulus(input logic [31:0] adr, input logic [31:0] data, input result_t e);
    memwrite  = 1'b1;
    dataadr   = adr;
    writedata = data;
    expq.push_back(e);
    @(negedge clk);
    memwrite  = 1'b0;
    dataadr   = 'x;
    writedata = 'x;
  endtask

  task automatic idle(input int n);
    memwrite  = 1'b0;
    dataadr   = 'x;
    writedata = 'x;
    repeat (n) @(negedge clk);
  endtask

  task automatic doReset(input int n);
    reset    = 1'b1;
    memwrite = 1'b0;
`ifdef STORE_LOG_EN
    log_rd      = 1'b0;
    logOvfModel = 1'b0;
    logModel.delete();
`endif
    repeat (n) @(negedge clk);
    expq.push_back(mk(0, 0, 0, 2'b00, 8'd0));
    checkOutput("reset");
    reset = 1'b0;
  endtask

`ifdef STORE_LOG_EN
  task automatic logCycle(input logic st, input logic [31:0] adr, input logic [31:0] data,
                          input logic rd, input string name);
    logic [63:0] e;
    memwrite  = st;
    dataadr   = adr;
    writedata = data;
    log_rd    = rd;
    if (rd) begin
      if (logModel.size() > 0) begin
        e = logModel.pop_front();
        cmp({name, ".valid"}, {31'd0, log_valid}, 32'd1);
        cmp({name, ".adr"}, log_adr, e[63:32]);
        cmp({name, ".data"}, log_data, e[31:0]);
      end else begin
        cmp({name, ".valid_empty"}, {31'd0, log_valid}, 32'd0);
      end
    end
    if (st) begin
      if (logModel.size() < 4) logModel.push_back({adr, data});
      else logOvfModel = 1'b1;
    end
    @(negedge clk);
    memwrite = 1'b0;
    log_rd   = 1'b0;
  endtask
`endif

  initial begin
    reset     = 1'b1;
    memwrite  = 1'b0;
    dataadr   = '0;
    writedata = '0;
`ifdef STORE_LOG_EN
    log_rd      = 1'b0;
    logOvfModel = 1'b0;
`endif

    vectors[0] = mkVec(PASSADR,  PASSDATA,      mk(1, 1, 0, 2'b00, 8'd1));
    vectors[1] = mkVec(PASSADR,  32'd5,         mk(1, 0, 1, 2'b10, 8'd1));
    vectors[2] = mkVec(32'd88,   32'd0,         mk(1, 0, 1, 2'b01, 8'd1));
    vectors[3] = mkVec(ALLOWADR, 32'd7,         mk(0, 0, 0, 2'b00, 8'd1));
    vectors[4] = mkVec(32'd0,    PASSDATA,      mk(1, 0, 1, 2'b01, 8'd1));
    vectors[5] = mkVec(PASSADR,  32'hFFFF_FFC1, mk(1, 0, 1, 2'b10, 8'd1));
    vectors[6] = mkVec(32'd81,   32'd0,         mk(1, 0, 1, 2'b01, 8'd1));

    for (int i = 0; i < 7; i++) begin
      doReset(1);
      applyStimulus(vectors[i].adr, vectors[i].data, vectors[i].exp);
      checkOutput($sformatf("vec%0d", i));
    end

    // Allowed store then passing store.
    doReset(2);
    applyStimulus(ALLOWADR, 32'd7, mk(0, 0, 0, 2'b00, 8'd1));
    checkOutput("seq_allow");
    applyStimulus(PASSADR, PASSDATA, mk(1, 1, 0, 2'b00, 8'd2));
    checkOutput("seq_pass");

    // Wrong data is sticky; later stores are ignored.
    doReset(1);
    applyStimulus(PASSADR, 32'd5, mk(1, 0, 1, 2'b10, 8'd1));
    checkOutput("sticky_fail");
    applyStimulus(PASSADR, PASSDATA, mk(1, 0, 1, 2'b10, 8'd1));
    checkOutput("sticky_ignore");

    // Reset out of FAIL restarts the run.
    doReset(1);
    applyStimulus(PASSADR, PASSDATA, mk(1, 1, 0, 2'b00, 8'd1));
    checkOutput("reset_from_fail");

    // Timeout with X on the bus while memwrite is low.
    doReset(1);
    idle(19);
    expq.push_back(mk(0, 0, 0, 2'b00, 8'd0));
    checkOutput("tmo_before");
    idle(1);
    expq.push_back(mk(1, 0, 1, 2'b11, 8'd0));
    checkOutput("tmo_hit");
    applyStimulus(PASSADR, PASSDATA, mk(1, 0, 1, 2'b11, 8'd0));
    checkOutput("tmo_sticky");

    // Store on the timeout cycle takes priority.
    doReset(1);
    idle(19);
    applyStimulus(PASSADR, PASSDATA, mk(1, 1, 0, 2'b00, 8'd1));
    checkOutput("tmo_priority");

    // store_count saturates at 255.
    doReset(1);
    for (int i = 0; i < 300; i++) begin
      memwrite  = 1'b1;
      dataadr   = ALLOWADR;
      writedata = i;
      @(negedge clk);
    end
    idle(0);
    expq.push_back(mk(0, 0, 0, 2'b00, 8'd255));
    checkOutput("saturate");
    applyStimulus(PASSADR, PASSDATA, mk(1, 1, 0, 2'b00, 8'd255));
    checkOutput("saturate_pass");

`ifdef STORE_LOG_EN
    // Six stores without reads: first four kept, overflow flagged.
    doReset(1);
    for (int i = 1; i <= 6; i++) logCycle(1'b1, ALLOWADR, i, 1'b0, "fill");
    cmp("ovf_set", {31'd0, log_ovf}, {31'd0, logOvfModel});
    for (int i = 0; i < 4; i++) logCycle(1'b0, 32'd0, 32'd0, 1'b1, $sformatf("drain%0d", i));
    cmp("drained", {31'd0, log_valid}, 32'd0);

    // Store and pop together while full: no overflow.
    doReset(1);
    for (int i = 1; i <= 4; i++) logCycle(1'b1, ALLOWADR, i, 1'b0, "fill2");
    logCycle(1'b1, ALLOWADR, 32'd5, 1'b1, "swap");
    cmp("no_ovf", {31'd0, log_ovf}, {31'd0, logOvfModel});
    for (int i = 0; i < 4; i++) logCycle(1'b0, 32'd0, 32'd0, 1'b1, $sformatf("drain2_%0d", i));
    logCycle(1'b0, 32'd0, 32'd0, 1'b1, "rd_empty");
    logCycle(1'b1, ALLOWADR, 32'd9, 1'b0, "after_empty");
    logCycle(1'b0, 32'd0, 32'd0, 1'b1, "wrap_read");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_monitor.md
STORE_MONITOR -- requirements
Module: store_monitor

Interface
REQ-001 Parameter PASS_ADR, default 32'd84, SHALL be the store address that ends the run.
REQ-002 Parameter PASS_DATA, default 32'hFFFF_FFC0 (-64), SHALL be the data required at PASS_ADR for a pass.
REQ-003 Parameter ALLOW_ADR, default 32'd80, SHALL be the only other store address permitted during a run.
REQ-004 Parameter TIMEOUT, default 16'd1000, SHALL be the run length in cycles before a timeout fail.
REQ-005 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 memwrite  in  1  store strobe from the multicycle processor, one cycle per store.
REQ-008 dataadr  in  32  store address, valid when memwrite=1.
REQ-009 writedata  in  32  store data, valid when memwrite=1.
REQ-010 done  out  1  high once a terminal state is reached.
REQ-011 pass  out  1  high in state PASS.
REQ-012 fail  out  1  high in states FAIL or TMO.
REQ-013 fail_code  out  2  00 none, 01 illegal address, 10 wrong data at PASS_ADR, 11 timeout.
REQ-014 store_count  out  8  number of stores seen in RUN, saturating at 255.
REQ-015 log_rd, log_valid, log_adr[31:0], log_data[31:0], log_ovf SHALL exist only when STORE_LOG_EN is defined.

Function
REQ-016 The FSM SHALL have states RUN, PASS, FAIL, TMO; PASS, FAIL and TMO SHALL be sticky until reset.
REQ-017 In RUN, a store (memwrite=1) SHALL be evaluated on the clock edge on which it is sampled; outputs SHALL reflect it one cycle later.
REQ-018 Store to PASS_ADR with writedata==PASS_DATA -> PASS, fail_code 00.
REQ-019 Store to PASS_ADR with any other data -> FAIL, fail_code 10.
REQ-020 Store to ALLOW_ADR -> remain in RUN; store to any other address -> FAIL, fail_code 01.
REQ-021 A 16-bit cycle counter SHALL increment every cycle in RUN; when it equals TIMEOUT-1 with no store that cycle, FSM -> TMO, fail_code 11.
REQ-022 A store sampled on the timeout cycle SHALL take priority over the timeout.
REQ-023 store_count SHALL increment on every store in RUN, including the terminating store, and SHALL hold at 255.
REQ-024 Stores in terminal states SHALL be ignored: no count change, no state change.
REQ-025 done SHALL equal pass|fail; pass and fail SHALL never be high together.
REQ-026 X/Z on dataadr or writedata with memwrite=0 SHALL have no effect.

Reset
REQ-027 When reset=1 at a rising edge: state RUN, cycle counter 0, store_count 0, fail_code 00, done/pass/fail 0.
REQ-028 Reset asserted mid-run or in a terminal state SHALL restart the run in the following cycle.
REQ-029 With STORE_LOG_EN, reset SHALL empty the log and clear log_ovf.

Configuration
REQ-030 Macro STORE_LOG_EN defined: a 4-entry FIFO SHALL record {dataadr, writedata} of every store counted in RUN.
REQ-031 log_valid=1 when the FIFO is non-empty; log_adr/log_data SHALL show the oldest entry; log_rd=1 with log_valid=1 SHALL pop it.
REQ-032 Store while full and no pop -> entry dropped, log_ovf set sticky; store and pop in the same cycle while full -> both performed.
REQ-033 log_rd while empty SHALL be ignored; pointers SHALL wrap modulo 4.
REQ-034 Macro undefined: no FIFO logic and no log ports; all other behaviour identical.

Verification
REQ-035 Reset 2 cycles, store (80, 7), then (84, -64) -> pass=1, done=1, fail_code 00, store_count 2.
REQ-036 Reset, store (84, 5) -> fail=1, fail_code 10, store_count 1; a later store (84, -64) -> no change.
REQ-037 Reset, store (88, 0) -> fail=1, fail_code 01.
REQ-038 TIMEOUT=20, no stores -> fail_code 11 one cycle after cycle 19; a store (84, -64) on cycle 19 -> pass instead.
REQ-039 Reset asserted while in FAIL, then store (84, -64) -> pass=1, store_count 1.
REQ-040 STORE_LOG_EN, six stores to 80 without log_rd -> four entries popped in order, log_ovf=1; simultaneous store and pop when full -> no overflow.
